wb_buffer: RTL and testbench
============================

WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of pending write entries (power of two, 2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  producer (ALU/MEM result) offers a write.
REQ-005 SHALL have port: in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 SHALL have port: in_wnum  input  5  destination register index.
REQ-007 SHALL have port: in_wdata  input  32  result data.
REQ-008 SHALL have port: rd_req  input  1  controller needs a register-read cycle; the write port must be idle.
REQ-009 SHALL have port: flush  input  1  discard all pending entries.
REQ-010 SHALL have port: we  output  1  register-file write enable.
REQ-011 SHALL have port: wnum  output  5  register-file write index.
REQ-012 SHALL have port: wdata  output  32  register-file write data.
REQ-013 SHALL have port: busy_mask  output  16  bit i = a pending entry targets r(i).
REQ-014 SHALL have port: count  output  4  number of valid entries (0..DEPTH).
REQ-015 SHALL have port: ovf  output  1  sticky flag, push attempted while full.
REQ-016 SHALL have ports: rnum_A/rnum_B  input  5 each; fwd_A_hit/fwd_B_hit  output  1 each; fwd_A_data/fwd_B_data  output  32 each; forwarding lookup.

Function
REQ-017 SHALL implement a circular FIFO with head/tail pointers and an occupancy counter.
REQ-018 SHALL drive in_ready = (count < DEPTH) and flush == 0; a full buffer does not accept, even if it pops in the same cycle.
REQ-019 SHALL push when in_valid && in_ready; a push with in_wnum == 0 or in_wnum >= 16 is accepted and dropped (no entry, no count change).
REQ-020 SHALL assert we combinationally when count > 0 && !rd_req && !flush, with wnum/wdata = head entry; the head pops on the same edge.
REQ-021 SHALL drive we = 0 and wnum/wdata = 0 when not writing.
REQ-022 SHALL give a latency of one cycle: an entry pushed at edge N into an empty buffer drives we during cycle N+1 unless rd_req is set.
REQ-023 SHALL update count by +1, -1 or 0 on simultaneous push and pop.
REQ-024 SHALL let pointers wrap modulo DEPTH with no bubble.
REQ-025 SHALL, on flush, clear count, pointers and busy_mask on the next edge, ignore any push that cycle, and hold we = 0.
REQ-026 SHALL set ovf on in_valid && !in_ready && !flush; ovf clears only on reset.
REQ-027 SHALL compute busy_mask combinationally from valid entries; duplicate targets keep the bit set until the last matching entry pops.
REQ-028 SHALL hold rd_req priority over draining; with rd_req asserted continuously, the buffer fills to DEPTH and then deasserts in_ready.

Reset
REQ-029 SHALL, with rst low at an edge, set count=0, pointers=0, ovf=0; we=0, wnum=0, wdata=0, busy_mask=0, in_ready=1 and fwd_*=0 the following cycle.
REQ-030 SHALL drop all pending entries on reset mid-operation; they are never written.

Configuration
REQ-031 SHALL, with WB_FWD_EN defined, drive fwd_X_hit = 1 and fwd_X_data = youngest valid entry whose index equals rnum_X (X = A, B), and fwd_X_hit = 0 for rnum_X == 0.
REQ-032 SHALL, without WB_FWD_EN, keep the forwarding ports present and tied to 0.

Structure
REQ-033 SHALL put REG_IDX_W=5, DATA_W=32, NUM_ARCH_REGS=16 and the wb_entry_t typedef (wnum, wdata) in shared package wb_pkg.
REQ-034 SHALL place storage and pointer logic in sub-module wb_fifo; wb_buffer adds filtering, the write-port gate, busy_mask, ovf and forwarding.

Verification
REQ-035 SHALL cover: push (r3, 0x0000_00AA) into empty, rd_req=0 -> next cycle we=1, wnum=3, wdata=0xAA; busy_mask[3] high one cycle.
REQ-036 SHALL cover: rd_req=1 held, push 5 entries with DEPTH=4 -> count=4, in_ready=0, ovf=1; release rd_req -> 4 writes on consecutive cycles in FIFO order.
REQ-037 SHALL cover: push r0 and r20 -> accepted, count stays 0, we never asserted.
REQ-038 SHALL cover: 3 pending entries, flush=1 with in_valid=1 -> next cycle count=0, busy_mask=0, no write issued.
REQ-039 SHALL cover: WB_FWD_EN, pending r7=0x11 then r7=0x22, rnum_A=7 -> fwd_A_hit=1, fwd_A_data=0x22; without the macro -> 0/0.
REQ-040 SHALL cover: rst low with 2 pending entries -> all outputs at reset values next cycle, no writes after reset.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back buffer.
// Forwarding is enabled by defining WB_FWD_EN.
package wb_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int DATA_W        = 32;
  localparam int NUM_ARCH_REGS = 16;

  typedef struct packed {
    logic [REG_IDX_W-1:0] wnum;
    logic [DATA_W-1:0]    wdata;
  } wb_entry_t;

  // r0 is hardwired and indices past the arch file have no storage
  function automatic logic is_arch_reg(
    input logic [REG_IDX_W-1:0] r
  );
    return (r != '0) &&
           (r < REG_IDX_W'(NUM_ARCH_REGS));
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store for wb_buffer: head/tail pointers plus occupancy.
// Build option WB_FWD_EN is handled in wb_buffer, not here.
import wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  wb_entry_t                  din,
  output wb_entry_t                  head_entry,
  output wb_entry_t [DEPTH-1:0]      slots,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [3:0]                 count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      count <= count + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      slots[tail] <= din;
  end

  assign head_entry = slots[head];

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer between execute results and the register-file port.
// Define WB_FWD_EN to enable youngest-entry forwarding on rnum_A/rnum_B.
import wb_pkg::*;

module wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_wnum,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic                 rd_req,
  input  logic                 flush,
  output logic                 we,
  output logic [REG_IDX_W-1:0] wnum,
  output logic [DATA_W-1:0]    wdata,
  output logic [15:0]          busy_mask,
  output logic [3:0]           count,
  output logic                 ovf,
  input  logic [REG_IDX_W-1:0] rnum_A,
  input  logic [REG_IDX_W-1:0] rnum_B,
  output logic                 fwd_A_hit,
  output logic                 fwd_B_hit,
  output logic [DATA_W-1:0]    fwd_A_data,
  output logic [DATA_W-1:0]    fwd_B_data
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t                 din;
  wb_entry_t                 head_entry;
  wb_entry_t [DEPTH-1:0]     slots;
  logic      [PTR_W-1:0]     head;
  logic                      push;
  logic                      pop;

  assign in_ready = (count < 4'(DEPTH)) && !flush;

  // invalid targets are handshaken but never stored
  assign push = in_valid && in_ready &&
                is_arch_reg(in_wnum);
  assign pop  = (count != '0) && !rd_req && !flush;
  assign din  = '{wnum: in_wnum, wdata: in_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .din        (din),
    .head_entry (head_entry),
    .slots      (slots),
    .head       (head),
    .count      (count)
  );

  assign we    = pop;
  assign wnum  = pop ? head_entry.wnum  : '0;
  assign wdata = pop ? head_entry.wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst)
      ovf <= 1'b0;
    else if (in_valid && !in_ready && !flush)
      ovf <= 1'b1;
  end

  always_comb begin
    busy_mask = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (4'(a) < count)
        busy_mask = busy_mask |
          (16'd1 << slots[head + PTR_W'(a)].wnum);
    end
  end

`ifdef WB_FWD_EN
  // walk oldest to youngest so the last match wins
  always_comb begin
    fwd_A_hit  = 1'b0;
    fwd_A_data = '0;
    fwd_B_hit  = 1'b0;
    fwd_B_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (4'(a) < count) begin
        if (rnum_A != '0 &&
            slots[head + PTR_W'(a)].wnum == rnum_A) begin
          fwd_A_hit  = 1'b1;
          fwd_A_data = slots[head + PTR_W'(a)].wdata;
        end
        if (rnum_B != '0 &&
            slots[head + PTR_W'(a)].wnum == rnum_B) begin
          fwd_B_hit  = 1'b1;
          fwd_B_data = slots[head + PTR_W'(a)].wdata;
        end
      end
    end
  end
`else
  logic unused_rnum;
  assign unused_rnum = ^{rnum_A, rnum_B};
  assign fwd_A_hit   = 1'b0;
  assign fwd_B_hit   = 1'b0;
  assign fwd_A_data  = '0;
  assign fwd_B_data  = '0;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: directed scenarios then random traffic,
// checked each cycle against a queue-based reference model.
module tb_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wnum;
  logic [31:0] in_wdata;
  logic        rd_req;
  logic        flush;
  logic        we;
  logic [4:0]  wnum;
  logic [31:0] wdata;
  logic [15:0] busy_mask;
  logic [3:0]  count;
  logic        ovf;
  logic [4:0]  rnum_A;
  logic [4:0]  rnum_B;
  logic        fwd_A_hit;
  logic        fwd_B_hit;
  logic [31:0] fwd_A_data;
  logic [31:0] fwd_B_data;

  always #5 clk = ~clk;

  wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wnum    (in_wnum),
    .in_wdata   (in_wdata),
    .rd_req     (rd_req),
    .flush      (flush),
    .we         (we),
    .wnum       (wnum),
    .wdata      (wdata),
    .busy_mask  (busy_mask),
    .count      (count),
    .ovf        (ovf),
    .rnum_A     (rnum_A),
    .rnum_B     (rnum_B),
    .fwd_A_hit  (fwd_A_hit),
    .fwd_B_hit  (fwd_B_hit),
    .fwd_A_data (fwd_A_data),
    .fwd_B_data (fwd_B_data)
  );

  typedef struct {
    logic [4:0]  n;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic fwd_model(input logic [4:0] r,
                           output logic hit,
                           output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_FWD_EN
    foreach (q[i]) begin
      if (r != 0 && q[i].n == r) begin
        hit = 1'b1;
        d   = q[i].d;
      end
    end
`endif
  endtask

  task automatic check_outputs();
    int          cnt;
    logic        e_we;
    logic [15:0] e_busy;
    logic        ha, hb;
    logic [31:0] da, db;
    cnt    = q.size();
    e_we   = (cnt > 0) && !rd_req && !flush;
    e_busy = '0;
    foreach (q[i]) e_busy[q[i].n[3:0]] = 1'b1;
    fwd_model(rnum_A, ha, da);
    fwd_model(rnum_B, hb, db);
    chk("count", 32'(count), 32'(cnt));
    chk("in_ready", 32'(in_ready),
        32'((cnt < DEPTH) && !flush));
    chk("we", 32'(we), 32'(e_we));
    chk("wnum", 32'(wnum), e_we ? 32'(q[0].n) : 0);
    chk("wdata", wdata, e_we ? q[0].d : 0);
    chk("busy_mask", 32'(busy_mask), 32'(e_busy));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("fwd_A_hit", 32'(fwd_A_hit), 32'(ha));
    chk("fwd_A_data", fwd_A_data, da);
    chk("fwd_B_hit", 32'(fwd_B_hit), 32'(hb));
    chk("fwd_B_data", fwd_B_data, db);
  endtask

  task automatic update_model();
    logic rdy, wr;
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      rdy = q.size() < DEPTH;
      wr  = q.size() > 0 && !rd_req;
      if (in_valid && !rdy) m_ovf = 1'b1;
      if (wr) void'(q.pop_front());
      if (in_valid && rdy && in_wnum != 0 && in_wnum < 16)
        q.push_back('{n: in_wnum, d: in_wdata});
    end
  endtask

  task automatic cycle(input logic r, input logic v,
                       input logic [4:0] n,
                       input logic [31:0] d,
                       input logic rd, input logic fl,
                       input logic [4:0] ra,
                       input logic [4:0] rb);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_wnum  = n;
    in_wdata = d;
    rd_req   = rd;
    flush    = fl;
    rnum_A   = ra;
    rnum_B   = rb;
    #1;
    if (chk_en) check_outputs();
    @(posedge clk);
    update_model();
  endtask

  task automatic idle(input logic rd);
    cycle(1, 0, 0, 0, rd, 0, 0, 0);
  endtask

  initial begin
    rst = 0; in_valid = 0; in_wnum = 0; in_wdata = 0;
    rd_req = 0; flush = 0; rnum_A = 0; rnum_B = 0;

    // reset from unknown state
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // single push into empty buffer
    cycle(1, 1, 5'd3, 32'hAA, 0, 0, 3, 3);
    cycle(1, 0, 0, 0, 0, 0, 3, 3);
    idle(0);

    // fill under rd_req, overflow, then drain in order
    for (int i = 1; i <= 5; i++)
      cycle(1, 1, 5'(i), 32'h100 + 32'(i), 1, 0, 5'(i), 2);
    idle(1);
    for (int i = 0; i < 5; i++) idle(0);

    // invalid targets dropped
    cycle(1, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0);
    cycle(1, 1, 5'd20, 32'hBEEF, 0, 0, 20, 0);
    idle(0);
    idle(0);

    // flush with a concurrent push
    for (int i = 0; i < 3; i++)
      cycle(1, 1, 5'(9 + i), 32'h900 + 32'(i), 1, 0, 0, 0);
    cycle(1, 1, 5'd12, 32'hC00, 0, 1, 9, 10);
    idle(0);
    idle(0);

    // duplicate targets: youngest forwards, busy until last pops
    cycle(1, 1, 5'd7, 32'h11, 1, 0, 7, 0);
    cycle(1, 1, 5'd7, 32'h22, 1, 0, 7, 0);
    cycle(1, 0, 0, 0, 1, 0, 7, 7);
    cycle(1, 0, 0, 0, 0, 0, 7, 7);
    cycle(1, 0, 0, 0, 0, 0, 7, 7);
    idle(0);

    // reset mid-operation
    cycle(1, 1, 5'd4, 32'h44, 1, 0, 4, 5);
    cycle(1, 1, 5'd5, 32'h55, 1, 0, 4, 5);
    cycle(0, 0, 0, 0, 0, 0, 4, 5);
    idle(0);
    idle(0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] n;
      n = ($urandom_range(0, 7) == 0) ?
          5'($urandom_range(0, 31)) :
          5'($urandom_range(1, 15));
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 2) != 0,
            n, $urandom,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 24) == 0,
            5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
